// File: rtl/video_mode_controller_if.sv
// Mode-request handshake between the control logic and the video mode controller.
interface video_mode_controller_if;
    logic       i_req_valid;
    logic [1:0] i_req_mode;
    logic       o_req_ready;
    logic       o_err;

    // Control logic side: issues requests, observes ready and error.
    modport master (
        output i_req_valid,
        output i_req_mode,
        input  o_req_ready,
        input  o_err
    );

    // Controller side.
    modport slave (
        input  i_req_valid,
        input  i_req_mode,
        output o_req_ready,
        output o_err
    );
endinterface

// File: rtl/video_mode_controller.sv
// Runtime video-mode sequencer: accepts mode requests, waits for a frame boundary,
// mutes DE for a number of whole frames, loads the new timing set and resumes output
// one frame later so the sink never sees a torn frame.
module video_mode_controller #(
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned MUTE_FRAMES  = 2,
    parameter int unsigned H_W          = 12,
    parameter int unsigned V_W          = 11
) (
    input  logic                   i_clk_pxl,
    input  logic                   i_reset,
    video_mode_controller_if.slave req,
    input  logic                   i_nf,
    input  logic                   i_de,
    output logic                   o_de_gated,
    output logic                   o_cfg_load,
    output logic [1:0]             o_mode,
    output logic                   o_busy,
    output logic [H_W-1:0]         o_h_active,
    output logic [H_W-1:0]         o_h_fp,
    output logic [H_W-1:0]         o_h_sync,
    output logic [H_W-1:0]         o_h_bp,
    output logic [V_W-1:0]         o_v_active,
    output logic [V_W-1:0]         o_v_fp,
    output logic [V_W-1:0]         o_v_sync,
    output logic [V_W-1:0]         o_v_bp,
    output logic [H_W-1:0]         o_h_total,
    output logic [V_W-1:0]         o_v_total,
    output logic                   o_hs_pol,
    output logic                   o_vs_pol
);

    // Mode table: 640x480, 1280x720, 800x600, 1920x1080.
    localparam int unsigned TAB_HA [4] = '{640, 1280, 800, 1920};
    localparam int unsigned TAB_HF [4] = '{16, 110, 40, 88};
    localparam int unsigned TAB_HS [4] = '{96, 40, 128, 44};
    localparam int unsigned TAB_HB [4] = '{48, 220, 88, 148};
    localparam int unsigned TAB_VA [4] = '{480, 720, 600, 1080};
    localparam int unsigned TAB_VF [4] = '{10, 5, 1, 4};
    localparam int unsigned TAB_VS [4] = '{2, 5, 4, 5};
    localparam int unsigned TAB_VB [4] = '{33, 20, 23, 36};
    localparam bit          TAB_POL[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    // Reject parameter sets the table or the mute counter cannot represent.
    if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_num_modes
        $fatal(1, "NUM_MODES must be 1..4");
    end
    if (DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
        $fatal(1, "DEFAULT_MODE must be below NUM_MODES");
    end
    if (MUTE_FRAMES < 1 || MUTE_FRAMES > 15) begin : g_bad_mute
        $fatal(1, "MUTE_FRAMES must be 1..15");
    end
    for (genvar g = 0; g < 4; g++) begin : g_total_chk
        if (TAB_HA[g] + TAB_HF[g] + TAB_HS[g] + TAB_HB[g] >= 2 ** H_W) begin : g_h_ovf
            $fatal(1, "horizontal total does not fit in H_W");
        end
        if (TAB_VA[g] + TAB_VF[g] + TAB_VS[g] + TAB_VB[g] >= 2 ** V_W) begin : g_v_ovf
            $fatal(1, "vertical total does not fit in V_W");
        end
    end

    typedef struct packed {
        logic [H_W-1:0] h_active;
        logic [H_W-1:0] h_fp;
        logic [H_W-1:0] h_sync;
        logic [H_W-1:0] h_bp;
        logic [H_W-1:0] h_total;
        logic [V_W-1:0] v_active;
        logic [V_W-1:0] v_fp;
        logic [V_W-1:0] v_sync;
        logic [V_W-1:0] v_bp;
        logic [V_W-1:0] v_total;
        logic           hs_pol;
        logic           vs_pol;
    } timing_t;

    function automatic timing_t lookup(input logic [1:0] m);
        timing_t     t;
        int unsigned i;
        i          = int'(m);
        t.h_active = H_W'(TAB_HA[i]);
        t.h_fp     = H_W'(TAB_HF[i]);
        t.h_sync   = H_W'(TAB_HS[i]);
        t.h_bp     = H_W'(TAB_HB[i]);
        t.h_total  = H_W'(TAB_HA[i] + TAB_HF[i] + TAB_HS[i] + TAB_HB[i]);
        t.v_active = V_W'(TAB_VA[i]);
        t.v_fp     = V_W'(TAB_VF[i]);
        t.v_sync   = V_W'(TAB_VS[i]);
        t.v_bp     = V_W'(TAB_VB[i]);
        t.v_total  = V_W'(TAB_VA[i] + TAB_VF[i] + TAB_VS[i] + TAB_VB[i]);
        t.hs_pol   = TAB_POL[i];
        t.vs_pol   = TAB_POL[i];
        return t;
    endfunction

    typedef enum logic [2:0] {
        StRun,
        StWaitNf,
        StMute,
        StLoad,
        StSettle
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] pend_q, pend_d;
    logic [3:0] mute_cnt_q, mute_cnt_d;
    logic       err_q, err_d;
    timing_t    timing_q, timing_d;

    logic accept;
    logic req_invalid;
    logic mute;

    assign accept      = req.i_req_valid && (state_q == StRun);
    assign req_invalid = (32'(req.i_req_mode) >= NUM_MODES);

    // State, pending mode and the live timing set; reset restores the default mode.
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            state_q    <= StRun;
            mode_q     <= 2'(DEFAULT_MODE);
            pend_q     <= 2'(DEFAULT_MODE);
            mute_cnt_q <= '0;
            err_q      <= 1'b0;
            timing_q   <= lookup(2'(DEFAULT_MODE));
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            mute_cnt_q <= mute_cnt_d;
            err_q      <= err_d;
            timing_q   <= timing_d;
        end
    end

    // Next-state: frame-aligned mode switch; the i_nf of the accept cycle is not counted.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        mute_cnt_d = mute_cnt_q;
        err_d      = 1'b0;
        timing_d   = timing_q;
        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (req_invalid) begin
                        err_d = 1'b1;
                    end else if (req.i_req_mode != mode_q) begin
                        pend_d  = req.i_req_mode;
                        state_d = StWaitNf;
                    end
                end
            end
            StWaitNf: begin
                if (i_nf) begin
                    mute_cnt_d = '0;
                    state_d    = StMute;
                end
            end
            StMute: begin
                if (i_nf) begin
                    if (mute_cnt_q == 4'(MUTE_FRAMES - 1)) begin
                        // New values must already be on the outputs during the load cycle.
                        mode_d   = pend_q;
                        timing_d = lookup(pend_q);
                        state_d  = StLoad;
                    end else begin
                        mute_cnt_d = mute_cnt_q + 4'd1;
                    end
                end
            end
            StLoad: begin
                state_d = StSettle;
            end
            StSettle: begin
                if (i_nf) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // DE mute: starts on the first frame boundary, ends on the frame after the load.
    always_comb begin
        mute = 1'b0;
        unique case (state_q)
            StRun:            mute = 1'b0;
            StWaitNf:         mute = i_nf;
            StMute, StLoad:   mute = 1'b1;
            StSettle:         mute = !i_nf;
            default:          mute = 1'b0;
        endcase
    end

    assign o_de_gated      = i_de && !mute;
    assign req.o_req_ready = (state_q == StRun);
    assign req.o_err       = err_q;
    assign o_busy          = (state_q != StRun);
    assign o_cfg_load      = (state_q == StLoad);
    assign o_mode          = mode_q;
    assign o_h_active      = timing_q.h_active;
    assign o_h_fp          = timing_q.h_fp;
    assign o_h_sync        = timing_q.h_sync;
    assign o_h_bp          = timing_q.h_bp;
    assign o_h_total       = timing_q.h_total;
    assign o_v_active      = timing_q.v_active;
    assign o_v_fp          = timing_q.v_fp;
    assign o_v_sync        = timing_q.v_sync;
    assign o_v_bp          = timing_q.v_bp;
    assign o_v_total       = timing_q.v_total;
    assign o_hs_pol        = timing_q.hs_pol;
    assign o_vs_pol        = timing_q.vs_pol;

endmodule
